stream_wb_burst_sink: RTL



---
 rtl/stream_wb_burst_sink.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/stream_wb_burst_sink.sv
// Stream-to-memory DMA stage: buffers a valid/ready word stream in a show-ahead FIFO and
// writes it out as Wishbone incrementing bursts starting at start_adr.

// Show-ahead FIFO: the head word is presented on rd_dat without a read strobe.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: wr_rdy drops in the cycle the registered count reaches depth.
module sink_fifo #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    output logic          wr_rdy,
    input  logic          rd_pop,
    output logic [DW-1:0] rd_dat,
    output logic [AW:0]   cnt
);
    localparam int DEPTH = 2**AW;
    localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push;

    always_comb begin
        push     = wr_vld && (cnt_q < FULL_CNT);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !rd_pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push && rd_pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

    assign wr_rdy = (cnt_q < FULL_CNT);
    assign rd_dat = mem_q[rd_ptr_q];
    assign cnt    = cnt_q;
endmodule

// Transfer engine: IDLE -> START -> WAIT -> BURST -> START ... -> IDLE with an irq pulse.
// Latency: enable edge to first strobe is 3 cycles when the FIFO already holds a burst.
// Backpressure: the stream is throttled only by FIFO fullness; the bus by ack wait states.
module stream_wb_burst_sink #(
    parameter int WB_DW         = 32,
    parameter int WB_AW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WB_DW-1:0]   stream_s_data_i,
    input  logic               stream_s_valid_i,
    output logic               stream_s_ready_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               enable,
    input  logic [WB_AW-1:0]   start_adr,
    input  logic [WB_AW-1:0]   buf_size,
    input  logic [WB_AW-1:0]   burst_size,
    output logic               busy,
    output logic               irq,
    output logic [WB_DW-1:0]   tx_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_BURST} state_t;

    localparam logic [WB_AW-1:0] ADR_STEP  = WB_AW'(WB_DW/8);
    localparam logic [WB_AW-1:0] ONE       = 1;
    localparam logic [WB_AW-1:0] MAX_BLEN  = WB_AW'(MAX_BURST_LEN);
    localparam logic [WB_DW-1:0] TX_ONE    = 1;

    state_t           state_q, state_d;
    logic             enable_q;
    logic [WB_AW-1:0] adr_q, adr_d;
    logic [WB_AW-1:0] rem_q, rem_d;
    logic [WB_AW-1:0] beats_q, beats_d;
    logic [WB_DW-1:0] tx_cnt_q, tx_cnt_d;
    logic             irq_q, irq_d;
    logic [WB_AW-1:0] blen;
    logic             pop;
    logic [WB_DW-1:0] fifo_head;
    logic [FIFO_AW:0] fifo_cnt;

    sink_fifo #(
        .DW (WB_DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (stream_s_valid_i),
        .wr_dat (stream_s_data_i),
        .wr_rdy (stream_s_ready_o),
        .rd_pop (pop),
        .rd_dat (fifo_head),
        .cnt    (fifo_cnt)
    );

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        rem_d    = rem_q;
        beats_d  = beats_q;
        tx_cnt_d = tx_cnt_q;
        irq_d    = 1'b0;
        pop      = 1'b0;

        blen = burst_size;
        if (burst_size == '0) begin
            blen = ONE;
        end else if (burst_size > MAX_BLEN) begin
            blen = MAX_BLEN;
        end

        case (state_q)
            S_IDLE: begin
                if (enable && !enable_q) begin
                    state_d  = S_START;
                    adr_d    = start_adr;
                    rem_d    = buf_size;
                    tx_cnt_d = '0;
                end
            end
            S_START: begin
                if (rem_q == '0) begin
                    state_d = S_IDLE;
                    irq_d   = 1'b1;
                end else begin
                    beats_d = (blen < rem_q) ? blen : rem_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Whole burst must be buffered so stb never has to drop mid-burst.
                if (WB_AW'(fifo_cnt) >= beats_q) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (wbm_err_i) begin
                    state_d = S_IDLE;
                    irq_d   = 1'b1;
                end else if (wbm_ack_i) begin
                    pop      = 1'b1;
                    adr_d    = adr_q + ADR_STEP;
                    rem_d    = rem_q - ONE;
                    tx_cnt_d = tx_cnt_q + TX_ONE;
                    beats_d  = beats_q - ONE;
                    if (beats_q == ONE) begin
                        state_d = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            enable_q <= 1'b0;
            adr_q    <= '0;
            rem_q    <= '0;
            beats_q  <= '0;
            tx_cnt_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable;
            adr_q    <= adr_d;
            rem_q    <= rem_d;
            beats_q  <= beats_d;
            tx_cnt_q <= tx_cnt_d;
            irq_q    <= irq_d;
        end
    end

    assign wbm_cyc_o = (state_q == S_BURST);
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_we_o  = wbm_cyc_o;
    assign wbm_cti_o = !wbm_cyc_o       ? 3'b000 :
                       (beats_q == ONE) ? 3'b111 : 3'b010;
    assign wbm_bte_o = 2'b00;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = fifo_head;
    assign wbm_sel_o = '1;
    assign busy      = (state_q != S_IDLE);
    assign irq       = irq_q;
    assign tx_cnt    = tx_cnt_q;
endmodule
